// File: rtl/tail_light_seq.sv
// Sequential tail-light controller: left/right sweep, hazard flash, brake overlay.
// All outputs are registered and decoded from the next-state values.
module tail_light_seq #(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 left,
    input  logic                 right,
    input  logic                 hazard,
    input  logic                 brake,
    output logic [2*LAMPS-1:0]   lights,
    output logic [3:0]           phase
);

    typedef enum logic [1:0] {
        MODE_IDLE,
        MODE_LEFT,
        MODE_RIGHT,
        MODE_FLASH
    } mode_t;

    localparam logic [3:0]  STEP_LAST = 4'(LAMPS);
    localparam logic [15:0] PRE_LAST  = 16'(TICK_DIV - 1);

    mode_t              mode;
    mode_t              mode_dec;
    mode_t              mode_nxt;
    logic [3:0]         step;
    logic [3:0]         step_nxt;
    logic [15:0]        pre;
    logic [15:0]        pre_nxt;
    logic               tick;
    logic [LAMPS-1:0]   left_seq;
    logic [LAMPS-1:0]   right_seq;
    logic [LAMPS-1:0]   left_drv;
    logic [LAMPS-1:0]   right_drv;
    logic [2*LAMPS-1:0] lights_nxt;

    // Brake is deliberately absent from the decode so it never disturbs sequencing.
    always_comb begin
        if (hazard || (left && right)) begin
            mode_dec = MODE_FLASH;
        end else if (left) begin
            mode_dec = MODE_LEFT;
        end else if (right) begin
            mode_dec = MODE_RIGHT;
        end else begin
            mode_dec = MODE_IDLE;
        end
    end

    assign tick = (pre == PRE_LAST);

    always_comb begin
        mode_nxt = mode;
        step_nxt = step;
        pre_nxt  = pre;
        if (mode_dec != mode) begin
            mode_nxt = mode_dec;
            step_nxt = (mode_dec == MODE_IDLE) ? 4'd0 : 4'd1;
            pre_nxt  = '0;
        end else begin
            case (mode)
                MODE_LEFT, MODE_RIGHT: begin
                    if (tick) begin
                        pre_nxt  = '0;
                        step_nxt = (step == STEP_LAST) ? 4'd0 : step + 4'd1;
                    end else begin
                        pre_nxt  = pre + 16'd1;
                    end
                end
                MODE_FLASH: begin
                    if (tick) begin
                        pre_nxt  = '0;
                        step_nxt = (step == 4'd0) ? 4'd1 : 4'd0;
                    end else begin
                        pre_nxt  = pre + 16'd1;
                    end
                end
                default: begin
                    step_nxt = '0;
                    pre_nxt  = '0;
                end
            endcase
        end
    end

    // Left half grows upward from its bit 0; right half grows downward from its top bit.
    always_comb begin
        left_seq  = '0;
        right_seq = '0;
        for (int unsigned i = 0; i < LAMPS; i++) begin
            left_seq[i]  = (5'(i) < {1'b0, step_nxt});
            right_seq[i] = ((5'(i) + {1'b0, step_nxt}) >= 5'(LAMPS));
        end
    end

    always_comb begin
        left_drv  = '0;
        right_drv = '0;
        case (mode_nxt)
            MODE_LEFT: begin
                left_drv = left_seq;
                if (brake) right_drv = '1;
            end
            MODE_RIGHT: begin
                right_drv = right_seq;
                if (brake) left_drv = '1;
            end
            MODE_FLASH: begin
                if (brake || (step_nxt != 4'd0)) begin
                    left_drv  = '1;
                    right_drv = '1;
                end
            end
            default: begin
                if (brake) begin
                    left_drv  = '1;
                    right_drv = '1;
                end
            end
        endcase
        lights_nxt = {left_drv, right_drv};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode   <= MODE_IDLE;
            step   <= '0;
            pre    <= '0;
            lights <= '0;
            phase  <= '0;
        end else begin
            mode   <= mode_nxt;
            step   <= step_nxt;
            pre    <= pre_nxt;
            lights <= lights_nxt;
            phase  <= step_nxt;
        end
    end

endmodule
